ps2_keycode_rx: RTL

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

---
 rtl/ps2_keycode_rx_pkg.sv | 29 ++
 rtl/ps2_keycode_rx_fifo.sv | 64 ++++++
 rtl/ps2_keycode_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keycode_rx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ps2_pkg : shared types and constants for the PS/2 keycode rx     |
// | Rev 1.0 : initial release                                        |
// +-----------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_entry_t;

  // frame holds {stop, parity, data[7:0]}; odd parity over data+parity
  function automatic logic frame_good(input logic [9:0] f);
    return f[9] & (^f[8:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keycode_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ps2_sync_fifo : show-ahead synchronous FIFO, power-of-two depth  |
// | Rev 1.0 : initial release                                        |
// +-----------------------------------------------------------------+
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is fine then
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_keycode_rx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ps2_keycode_rx : PS/2 frame receiver, scan-code decoder, FIFO    |
// | Option macro PS2_KEYCODE_RX_PREFIX_DECODE_EN folds E0/F0 prefixes|
// | Rev 1.0 : initial release                                        |
// +-----------------------------------------------------------------+
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic                          rx_valid,
  output logic [7:0]                    rx_data,
  output logic                          rx_break,
  output logic                          rx_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_KEYCODE_RX_PREFIX_DECODE_EN
  localparam int FIFO_W = $bits(ps2_entry_t);
`else
  localparam int FIFO_W = 8;
`endif

  logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic              filt_q, filt_d;
  logic [7:0]        filt_cnt_q, filt_cnt_d;
  logic              bit_strobe;
  ps2_state_t        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [9:0]        frame_q, frame_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              frame_err_q, frame_err_d;
  logic              frame_ok;
  logic              push_q, push_d;
  logic [FIFO_W-1:0] push_data_q, push_data_d;
  logic              overflow_q, overflow_d;
  logic [FIFO_W-1:0] fifo_dout;
  logic              fifo_empty, fifo_full, pop;
`ifdef PS2_KEYCODE_RX_PREFIX_DECODE_EN
  logic              brk_q, brk_d, ext_q, ext_d;
`endif

  // Filtered clock follows the synchroniser only after FILTER_LEN disagreeing samples
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    bit_strobe = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
        filt_d     = clk_s2_q;
        bit_strobe = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    to_cnt_d    = '0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bit_strobe && !dat_s2_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 4'd0;
        end
      end
      ST_SHIFT: begin
        if (bit_strobe) begin
          frame_d = {dat_s2_q, frame_q[9:1]};
          if (bit_cnt_q == 4'd9) begin
            state_d   = ST_CHECK;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
          bit_cnt_d   = 4'd0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_CHECK: begin
        state_d     = ST_IDLE;
        frame_err_d = ~frame_good(frame_q);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_ok = (state_q == ST_CHECK) && frame_good(frame_q);

  always_comb begin
    push_d      = 1'b0;
    push_data_d = push_data_q;
`ifdef PS2_KEYCODE_RX_PREFIX_DECODE_EN
    brk_d = brk_q;
    ext_d = ext_q;
    if (frame_ok) begin
      if (frame_q[7:0] == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (frame_q[7:0] == PS2_PREFIX_BREAK) begin
        brk_d = 1'b1;
      end else begin
        push_d      = 1'b1;
        push_data_d = {brk_q, ext_q, frame_q[7:0]};
        brk_d       = 1'b0;
        ext_d       = 1'b0;
      end
    end else if (state_q == ST_CHECK) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
`else
    if (frame_ok) begin
      push_d      = 1'b1;
      push_data_d = frame_q[7:0];
    end
`endif
  end

  assign pop        = rd_en & ~fifo_empty;
  assign overflow_d = push_q & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef PS2_KEYCODE_RX_PREFIX_DECODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
    end
  end
`endif

  ps2_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (push_data_q),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Head is gated so stale RAM contents never appear while empty
  assign rx_valid  = ~fifo_empty;
  assign rx_data   = rx_valid ? fifo_dout[7:0] : 8'h00;
`ifdef PS2_KEYCODE_RX_PREFIX_DECODE_EN
  assign rx_break  = rx_valid & fifo_dout[9];
  assign rx_ext    = rx_valid & fifo_dout[8];
`else
  assign rx_break  = 1'b0;
  assign rx_ext    = 1'b0;
`endif
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire
